// File: rtl/rr_grant_ctrl.sv
// Four-requester round-robin grant controller; the owner holds the grant until it drops its request.
// Define RR_GRANT_TIMEOUT_EN to force a release after MAX_HOLD consecutive grant cycles.
module rr_grant_ctrl #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             owner_req;
    logic             force_rel;

    if (MAX_HOLD == 0 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_grant_ctrl: MAX_HOLD must be within 1..15");
    end

    function automatic logic [N_REQ-1:0] decode(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Winner is the first set request scanning upward from ptr; the descending loop lets the nearest one win.
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    assign owner_req = req[gnt_idx];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;

    // hold_cnt counts completed grant cycles; it sits at zero in IDLE so every grant starts fresh.
    assign force_rel = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout  <= (state == GRANT) && owner_req && force_rel;
            hold_cnt <= (state == GRANT) ? hold_cnt + CNT_W'(1) : '0;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Arbitration FSM; gnt and busy are registered alongside the state so they never see req combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= GRANT;
                        gnt_idx <= win_idx;
                        gnt     <= decode(win_idx);
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!owner_req || force_rel) begin
                        state <= IDLE;
                        ptr   <= gnt_idx + IDX_W'(1);
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: directed scenarios plus random requests against a behavioural model.
module tb_rr_grant_ctrl;

    localparam int unsigned MAX_HOLD = 4;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req   = 4'hF;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    rr_grant_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       to;
        logic       busy;
        logic [1:0] idx;
        logic [3:0] gnt;
    } obs_t;

    obs_t       exp_q[$];
    logic [4:0] obs_log[$];
    logic [4:0] exp_log[$];
    logic [3:0] stim[$];
    obs_t       mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current owner (-1 when none), next priority position, cycles the owner has held, last owner.
    int   m_owner;
    int   m_next;
    int   m_held;
    int   m_last;
    logic m_to;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_next  = 0;
        m_held  = 0;
        m_last  = 0;
        m_to    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] r, output obs_t e);
        int c;
        bit found;
        m_to = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_next + k) % 4;
                if (!found && r[c]) begin
                    m_owner = c;
                    found   = 1'b1;
                end
            end
            if (found) begin
                m_held = 1;
                m_last = m_owner;
            end
        end else if (!r[m_owner]) begin
            m_next  = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (TO_EN && m_held == int'(MAX_HOLD)) begin
            m_next  = (m_owner + 1) % 4;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
        e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
        e.busy = (m_owner >= 0);
        e.idx  = 2'(m_last);
        e.to   = m_to;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic [3:0] r);
        obs_t e;
        req = r;
        model_step(r, e);
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        req   = 4'hF;
        model_reset();
        #1;
        check("reset_outputs", 16'({timeout, busy, gnt_idx, gnt}), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_log.delete();
    endtask

    task automatic run_stim();
        foreach (stim[i]) drive(stim[i]);
    endtask

    task automatic check_log(input string name);
        #1;
        check({name, "_len"}, 16'(obs_log.size()), 16'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 16'(obs_log[i]), 16'(exp_log[i]));
        end
    endtask

    // Monitor: one expected entry per clock edge, compared at the following falling edge.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("scoreboard@%0t", $time),
                  16'({timeout, busy, gnt_idx, gnt}), 16'(mon_e));
            obs_log.push_back({timeout, gnt});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        stim    = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
        run_stim();
        exp_log = '{5'h04, 5'h04, 5'h04, 5'h00, 5'h00};
        check_log("single");

        do_reset();
        stim    = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
        run_stim();
        exp_log = '{5'h01, 5'h00, 5'h02, 5'h00, 5'h04, 5'h00, 5'h08, 5'h00, 5'h01};
        check_log("rotation");

        do_reset();
        stim    = '{4'h8, 4'h9, 4'h9, 4'h1, 4'h1};
        run_stim();
        exp_log = '{5'h08, 5'h08, 5'h08, 5'h00, 5'h01};
        check_log("wrap");

        do_reset();
        stim    = '{4'h2, 4'h5, 4'h5};
        run_stim();
        exp_log = '{5'h02, 5'h00, 5'h04};
        check_log("simultaneous");

        do_reset();
        stim    = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
        run_stim();
`ifdef RR_GRANT_TIMEOUT_EN
        exp_log = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h10, 5'h02, 5'h02, 5'h02, 5'h02, 5'h10, 5'h01};
`else
        exp_log = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01};
`endif
        check_log("hold");

        // Reset dropped in the middle of a grant must clear gnt before the next edge.
        do_reset();
        drive(4'h4);
        drive(4'h4);
        #1;
        check("pre_reset_gnt", 16'(gnt), 16'h4);
        do_reset();
        stim    = '{4'hF, 4'hF};
        run_stim();
        exp_log = '{5'h01, 5'h01};
        check_log("post_reset_ptr");

        for (int round = 0; round < 3; round++) begin
            do_reset();
            repeat (600) begin
                if ($urandom_range(0, 7) == 0) drive(4'h0);
                else drive(4'($urandom));
            end
        end

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
